// File: rtl/ibex_pkg.sv
// Shared types for the Ibex alert path: multi-bit fetch gate, alert handshake states
// and the major-cause payload.
package ibex_pkg;

    typedef enum logic [3:0] {
        IbexMuBiOn  = 4'b0101,
        IbexMuBiOff = 4'b1010
    } ibex_mubi_t;

    typedef enum logic [1:0] {
        AlertIdle,
        AlertReq,
        AlertDrain
    } alert_hs_e;

    localparam int unsigned AlertMinorCntW = 8;
    localparam int unsigned AlertCauseW    = 3;

    // Sticky major causes, msb first so the packed value matches major_cause_o.
    typedef struct packed {
        logic minor_esc;
        logic bus;
        logic internal;
    } major_cause_t;

    // Saturating increment for the per-window minor event count.
    function automatic logic [AlertMinorCntW-1:0] minor_cnt_inc(
        input logic [AlertMinorCntW-1:0] cnt
    );
        return (&cnt) ? cnt : cnt + AlertMinorCntW'(1);
    endfunction

endpackage

// File: rtl/ibex_alert_hs.sv
// Four-phase req/ack alert sender: one request per consumed alert, then waits for
// ack to rise and fall again before it can request anew.
module ibex_alert_hs
    import ibex_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic req_cond_i,
    input  logic ack_i,
    output logic consume_o,
    output logic req_o
);

    alert_hs_e state_q, state_d;
    logic      req_d, req_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= AlertIdle;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
        end
    end

    // A stale ack left over in Idle blocks a new request until it drops.
    always_comb begin
        state_d = state_q;
        case (state_q)
            AlertIdle:  if (req_cond_i && !ack_i) state_d = AlertReq;
            AlertReq:   if (ack_i)                state_d = AlertDrain;
            AlertDrain: if (!ack_i)               state_d = AlertIdle;
            default:                              state_d = AlertIdle;
        endcase
    end

    always_comb begin
        consume_o = 1'b0;
        req_d     = 1'b0;
        consume_o = (state_q == AlertIdle) && (state_d == AlertReq);
        req_d     = (state_d == AlertReq);
    end

    assign req_o = req_q;

endmodule

// File: rtl/ibex_alert_aggregator.sv
// Merges lockstep and core alerts into minor/major four-phase alert channels,
// escalates minor bursts within a window and gates instruction fetch on any major cause.
module ibex_alert_aggregator
    import ibex_pkg::*;
#(
    parameter int unsigned MinorEscThreshold = 4,
    parameter int unsigned MinorWindowCycles = 1024,
    parameter int unsigned PendingWidth      = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             ls_alert_minor_i,
    input  logic             ls_alert_major_internal_i,
    input  logic             ls_alert_major_bus_i,
    input  logic             core_alert_minor_i,
    input  logic             core_alert_major_internal_i,
    input  logic             core_alert_major_bus_i,
    output logic             minor_alert_req_o,
    input  logic             minor_alert_ack_i,
    output logic             major_alert_req_o,
    input  logic             major_alert_ack_i,
    output logic [2:0]       major_cause_o,
    output logic [7:0]       minor_count_o,
    output ibex_mubi_t       fetch_enable_o
);

    localparam int unsigned WinW = (MinorWindowCycles > 1) ? $clog2(MinorWindowCycles) : 1;
    localparam logic [WinW-1:0]         WinLast    = WinW'(MinorWindowCycles - 1);
    localparam logic [PendingWidth-1:0] PendingMax = {PendingWidth{1'b1}};

    logic                      minor_event;
    logic                      minor_req_cond;
    logic                      minor_consume;
    logic                      major_consume;
    logic                      major_active_c;
    logic                      win_wrap;
    logic                      esc_c;
    logic [PendingWidth-1:0]   pending_q, pending_d;
    logic [WinW-1:0]           win_q, win_d;
    logic [AlertMinorCntW-1:0] minor_cnt_q, minor_cnt_d;
    major_cause_t              cause_q, cause_d;
    ibex_mubi_t                fetch_q, fetch_d;

    assign minor_event    = ls_alert_minor_i | core_alert_minor_i;
    assign minor_req_cond = minor_event | (pending_q != '0);

    // The arriving event is handed straight to the FSM when it starts a request,
    // so pending only moves when exactly one of arrive/consume applies.
    always_comb begin
        pending_d = pending_q;
        if (minor_consume && !minor_event) begin
            pending_d = pending_q - PendingWidth'(1);
        end else if (minor_event && !minor_consume && (pending_q != PendingMax)) begin
            pending_d = pending_q + PendingWidth'(1);
        end
    end

    assign win_wrap = (win_q == WinLast);
    assign win_d    = win_wrap ? '0 : win_q + WinW'(1);

    always_comb begin
        minor_cnt_d = minor_cnt_q;
        if (win_wrap) begin
            minor_cnt_d = minor_event ? AlertMinorCntW'(1) : '0;
        end else if (minor_event) begin
            minor_cnt_d = minor_cnt_inc(minor_cnt_q);
        end
    end

    assign esc_c = (MinorEscThreshold != 0) && (32'(minor_cnt_d) >= MinorEscThreshold);

    always_comb begin
        cause_d           = cause_q;
        cause_d.internal  = cause_q.internal  | ls_alert_major_internal_i | core_alert_major_internal_i;
        cause_d.bus       = cause_q.bus       | ls_alert_major_bus_i      | core_alert_major_bus_i;
        cause_d.minor_esc = cause_q.minor_esc | esc_c;
    end

    // Next-state view so a fresh cause requests and gates fetch in the following cycle.
    assign major_active_c = |cause_d;
    assign fetch_d        = major_active_c ? IbexMuBiOff : IbexMuBiOn;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q   <= '0;
            win_q       <= '0;
            minor_cnt_q <= '0;
            cause_q     <= '0;
            fetch_q     <= IbexMuBiOn;
        end else begin
            pending_q   <= pending_d;
            win_q       <= win_d;
            minor_cnt_q <= minor_cnt_d;
            cause_q     <= cause_d;
            fetch_q     <= fetch_d;
        end
    end

    ibex_alert_hs u_minor_hs (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .req_cond_i (minor_req_cond),
        .ack_i      (minor_alert_ack_i),
        .consume_o  (minor_consume),
        .req_o      (minor_alert_req_o)
    );

    ibex_alert_hs u_major_hs (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .req_cond_i (major_active_c),
        .ack_i      (major_alert_ack_i),
        .consume_o  (major_consume),
        .req_o      (major_alert_req_o)
    );

    // A major request can only ever start from an active cause.
    major_req_needs_cause: assert property (
        @(posedge clk_i) disable iff (!rst_ni) major_consume |-> major_active_c
    );

    assign major_cause_o  = cause_q;
    assign minor_count_o  = minor_cnt_q;
    assign fetch_enable_o = fetch_q;

endmodule

// File: tb/tb_ibex_alert_aggregator.sv
// Scoreboard bench for ibex_alert_aggregator: a cycle-level reference model queues the
// expected outputs and a monitor compares them; directed scenarios add fixed checks.
module tb_ibex_alert_aggregator;
    import ibex_pkg::*;

    localparam int Thr     = 4;
    localparam int Win     = 1024;
    localparam int PendMax = 7;

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic       ls_min = 1'b0, ls_int = 1'b0, ls_bus = 1'b0;
    logic       co_min = 1'b0, co_int = 1'b0, co_bus = 1'b0;
    logic       minor_ack = 1'b0, major_ack = 1'b0;
    logic       minor_req, major_req;
    logic [2:0] cause;
    logic [7:0] count;
    ibex_mubi_t fetch;

    ibex_alert_aggregator #(
        .MinorEscThreshold (Thr),
        .MinorWindowCycles (Win),
        .PendingWidth      (3)
    ) dut (
        .clk_i                       (clk),
        .rst_ni                      (rst_ni),
        .ls_alert_minor_i            (ls_min),
        .ls_alert_major_internal_i   (ls_int),
        .ls_alert_major_bus_i        (ls_bus),
        .core_alert_minor_i          (co_min),
        .core_alert_major_internal_i (co_int),
        .core_alert_major_bus_i      (co_bus),
        .minor_alert_req_o           (minor_req),
        .minor_alert_ack_i           (minor_ack),
        .major_alert_req_o           (major_req),
        .major_alert_ack_i           (major_ack),
        .major_cause_o               (cause),
        .minor_count_o               (count),
        .fetch_enable_o              (fetch)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            if (failures <= 30)
                $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic       mreq;
        logic       jreq;
        logic [2:0] cause;
        logic [7:0] cnt;
        logic [3:0] fetch;
    } obs_t;

    obs_t       exp_q[$];
    int         m_wait, m_phase, j_phase, m_tick, m_cnt;
    logic [2:0] m_cause;

    function automatic void model_reset();
        m_wait = 0; m_phase = 0; j_phase = 0; m_tick = 0; m_cnt = 0; m_cause = 3'b000;
    endfunction

    // Channel phase: 0 = waiting for work, 1 = requesting, 2 = waiting for ack release.
    function automatic int hs_next(input int ph, input bit want_req, input bit ack, output bit start);
        start = 1'b0;
        if (ph == 0) begin
            if (want_req && !ack) begin start = 1'b1; return 1; end
            return 0;
        end
        if (ph == 1) return ack ? 2 : 1;
        return ack ? 2 : 0;
    endfunction

    task automatic model_step();
        bit   ev, m_start, j_start;
        obs_t o;
        ev = ls_min | co_min;
        m_phase = hs_next(m_phase, ev || (m_wait > 0), minor_ack, m_start);
        if (m_start && !ev) m_wait--;
        else if (ev && !m_start && m_wait < PendMax) m_wait++;
        if (m_tick == Win - 1) m_cnt = ev ? 1 : 0;
        else if (ev) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        m_tick = (m_tick + 1) % Win;
        if (Thr != 0 && m_cnt >= Thr) m_cause[2] = 1'b1;
        if (ls_int || co_int) m_cause[0] = 1'b1;
        if (ls_bus || co_bus) m_cause[1] = 1'b1;
        j_phase = hs_next(j_phase, m_cause != 3'b000, major_ack, j_start);
        o.mreq  = (m_phase == 1);
        o.jreq  = (j_phase == 1);
        o.cause = m_cause;
        o.cnt   = 8'(m_cnt);
        o.fetch = (m_cause != 3'b000) ? IbexMuBiOff : IbexMuBiOn;
        exp_q.push_back(o);
    endtask

    always @(posedge clk) if (rst_ni) model_step();

    // ---------------- monitor ----------------
    logic prev_m = 1'b0, prev_j = 1'b0;
    int   cyc_no = 0, m_rises = 0, j_rises = 0;
    int   last_j_rise = -1, first_gap = -1, min_gap = 1000;
    bit   gap_bad = 1'b0;

    always @(negedge clk) begin
        obs_t got, want;
        int   gap;
        if (rst_ni) begin
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                got  = {minor_req, major_req, cause, count, fetch};
                chk("cycle_model", 32'(got), 32'(want));
            end
            if (minor_req && !prev_m) m_rises++;
            if (major_req && !prev_j) begin
                if (last_j_rise >= 0) begin
                    gap = cyc_no - last_j_rise;
                    if (first_gap < 0) first_gap = gap;
                    else if (gap != first_gap) gap_bad = 1'b1;
                    if (gap < min_gap) min_gap = gap;
                end
                last_j_rise = cyc_no;
                j_rises++;
            end
        end
        prev_m = minor_req;
        prev_j = major_req;
        cyc_no++;
    end

    // ---------------- ack responders: ack follows req delayed by N cycles ----------------
    logic [3:0] mh = '0, jh = '0;
    int         m_mode = 1, j_mode = 1, m_dly = 1, j_dly = 1;

    always @(negedge clk) begin
        mh = {mh[2:0], minor_req};
        jh = {jh[2:0], major_req};
    end

    always @(posedge clk) begin
        #1;
        minor_ack = (m_mode != 0) ? mh[m_dly-1] : 1'b0;
        major_ack = (j_mode != 0) ? jh[j_dly-1] : 1'b0;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic assert_reset();
        rst_ni = 1'b0;
        exp_q.delete();
        model_reset();
        ls_min = 0; ls_int = 0; ls_bus = 0; co_min = 0; co_int = 0; co_bus = 0;
        m_rises = 0; j_rises = 0; last_j_rise = -1; first_gap = -1; min_gap = 1000; gap_bad = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        assert_reset();
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_minor_req"}, 32'(minor_req), 0);
        chk({tag, "_major_req"}, 32'(major_req), 0);
        chk({tag, "_cause"}, 32'(cause), 0);
        chk({tag, "_count"}, 32'(count), 0);
        chk({tag, "_fetch"}, 32'(fetch), 32'(IbexMuBiOn));
    endtask

    initial begin
        logic [3:0] pat;

        // Reset state
        do_reset();
        smp();
        chk_reset_vals("rst");

        // Single lockstep minor pulse, ack two cycles after req
        m_mode = 1; m_dly = 2; j_mode = 1; j_dly = 1;
        tick();
        ls_min = 1'b1;
        tick();
        ls_min = 1'b0;
        for (int i = 0; i < 4; i++) begin
            smp();
            pat[3-i] = minor_req;
            tick();
        end
        chk("single_req_pattern", 32'(pat), 32'(4'b1110));
        chk("single_count", 32'(count), 1);
        chk("single_cause", 32'(cause), 0);
        chk("single_fetch", 32'(fetch), 32'(IbexMuBiOn));

        // Backlog with ack held low: 1 taken, 7 pending, 1 dropped
        do_reset();
        m_mode = 0;
        tick();
        for (int i = 0; i < 9; i++) begin
            ls_min = i[0];
            co_min = !i[0];
            tick();
        end
        ls_min = 1'b0; co_min = 1'b0;
        smp();
        chk("backlog_count", 32'(count), 9);
        chk("backlog_first_req", 32'(minor_req), 1);
        chk("backlog_rises_held", 32'(m_rises), 1);
        m_mode = 1; m_dly = 1;
        repeat (60) tick();
        smp();
        chk("backlog_total_reqs", 32'(m_rises), 8);

        // Escalation after the 4th minor event in a window
        do_reset();
        m_mode = 1; m_dly = 1; j_mode = 1; j_dly = 1;
        tick();
        for (int i = 0; i < 4; i++) begin
            co_min = 1'b1;
            tick();
            co_min = 1'b0;
            if (i < 3) begin
                smp();
                chk("esc_pre_cause", 32'(cause), 0);
                tick();
            end
        end
        smp();
        chk("esc_cause", 32'(cause), 32'(3'b100));
        chk("esc_fetch", 32'(fetch), 32'(IbexMuBiOff));
        chk("esc_major_req", 32'(major_req), 1);
        chk("esc_count", 32'(count), 4);

        // 3 + 3 events split by a window wrap: no escalation
        do_reset();
        tick();
        for (int i = 0; i < 3; i++) begin ls_min = 1'b1; tick(); ls_min = 1'b0; tick(); end
        repeat (1030) tick();
        for (int i = 0; i < 3; i++) begin co_min = 1'b1; tick(); co_min = 1'b0; tick(); end
        smp();
        chk("window_count", 32'(count), 3);
        chk("window_no_esc", 32'(cause), 0);
        chk("window_fetch", 32'(fetch), 32'(IbexMuBiOn));

        // Major bus alert: sticky cause and repeating requests
        do_reset();
        j_mode = 1; j_dly = 1;
        tick();
        co_bus = 1'b1;
        tick();
        co_bus = 1'b0;
        smp();
        chk("bus_cause", 32'(cause), 32'(3'b010));
        chk("bus_req", 32'(major_req), 1);
        chk("bus_fetch", 32'(fetch), 32'(IbexMuBiOff));
        repeat (40) tick();
        smp();
        chk("bus_sticky", 32'(cause), 32'(3'b010));
        chk("bus_rises", 32'(j_rises >= 6), 1);
        chk("bus_gap_min", 32'(min_gap >= 3), 1);
        chk("bus_gap_uniform", 32'(gap_bad), 0);

        // Simultaneous internal + bus + minor, acks held low
        do_reset();
        m_mode = 0; j_mode = 0;
        tick();
        ls_int = 1'b1; co_bus = 1'b1; co_min = 1'b1;
        tick();
        ls_int = 1'b0; co_bus = 1'b0; co_min = 1'b0;
        smp();
        chk("simul_cause", 32'(cause), 32'(3'b011));
        chk("simul_minor_req", 32'(minor_req), 1);
        chk("simul_major_req", 32'(major_req), 1);
        chk("simul_count", 32'(count), 1);
        repeat (3) tick();

        // Reset mid-handshake: immediate, nothing left over afterwards
        @(posedge clk);
        #3;
        assert_reset();
        #1;
        chk_reset_vals("midrst");
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;
        m_mode = 1; j_mode = 1;
        repeat (10) tick();
        smp();
        chk("post_rst_minor_rises", 32'(m_rises), 0);
        chk("post_rst_major_rises", 32'(j_rises), 0);
        chk("post_rst_cause", 32'(cause), 0);

        // Randomized traffic checked by the model every cycle
        for (int seg = 0; seg < 2; seg++) begin
            do_reset();
            for (int c = 0; c < 1500; c++) begin
                if (c % 100 == 0) begin
                    m_dly  = $urandom_range(3, 1);
                    j_dly  = $urandom_range(3, 1);
                    m_mode = ($urandom_range(3, 0) != 0) ? 1 : 0;
                    j_mode = ($urandom_range(4, 0) != 0) ? 1 : 0;
                end
                ls_min = ($urandom_range(seg == 0 ? 7 : 3, 0) == 0);
                co_min = ($urandom_range(seg == 0 ? 7 : 3, 0) == 0);
                ls_int = (seg == 1) && ($urandom_range(799, 0) == 0);
                co_int = (seg == 1) && ($urandom_range(799, 0) == 0);
                ls_bus = (seg == 1) && ($urandom_range(799, 0) == 0);
                co_bus = (seg == 1) && ($urandom_range(799, 0) == 0);
                tick();
            end
            ls_min = 0; co_min = 0; ls_int = 0; co_int = 0; ls_bus = 0; co_bus = 0;
            repeat (5) tick();
        end

        smp();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
